vram_write_arbiter: RTL
=======================

// Module: vram_write_arbiter
// PURPOSE
//  Shares the single framebuffer write port (address/color/writeEnable into vga_ram) among N_REQ renderers
//  (maze redraw, sprites, score, ...) using round-robin with burst lock. Writes are optionally gated to vblank.
//  Sits between the graphics requesters and vga_ram; all write-port outputs are registered.
// PARAMETERS
//  N_REQ       4      number of requesters (>=2)
//  ADDR_W      16     framebuffer address width
//  DATA_W      8      pixel color width (RGB 3:3:2)
//  DEPTH       19200  framebuffer words; clear engine covers 0..DEPTH-1
//  MAX_BURST   64     max beats per grant before forced release (>=1)
//  GATE_VBLANK 1      1: beats accepted only while vblank=1; 0: vblank ignored
// PORTS
//  clk          in   1              clock
//  rst          in   1              async reset, active-high
//  vblank       in   1              write window from VGA timing
//  req          in   N_REQ          per-requester beat valid
//  last         in   N_REQ          marks final beat of requester's burst
//  addr         in   N_REQ*ADDR_W   packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//  data         in   N_REQ*DATA_W   packed colors, same packing
//  gnt          out  N_REQ          one-hot registered grant
//  wr_en        out  1              to vga_ram writeEnable
//  wr_addr      out  ADDR_W         to vga_ram address
//  wr_data      out  DATA_W         to vga_ram color
//  busy         out  1              state != IDLE
//  clear_req    in   1              (VRAM_ARB_CLEAR_EN only) pulse: start full-screen fill
//  clear_color  in   DATA_W         (VRAM_ARB_CLEAR_EN only) fill color, sampled with clear_req
//  clear_done   out  1              (VRAM_ARB_CLEAR_EN only) 1-cycle pulse after final fill write
// BEHAVIOUR
//  - Reset: state IDLE, gnt=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, clear_done=0, rr_ptr=0, beat_cnt=0.
//  - win = (vblank | ~GATE_VBLANK). Beat i accepted when req[i] & gnt[i] & win.
//  - IDLE: if win & |req, pick first set req at or after rr_ptr (cyclic); next cycle gnt=onehot(owner),
//    state BURST, beat_cnt=0. One dead cycle between bursts.
//  - BURST: each accepted beat -> next cycle wr_en=1, wr_addr/wr_data=owner's inputs (1-cycle latency);
//    otherwise wr_en=0. beat_cnt increments per beat.
//  - Release (gnt=0 next cycle, back to IDLE, rr_ptr=owner+1 mod N_REQ) on accepted beat with last[owner]
//    or beat_cnt reaching MAX_BURST.
//  - req[owner] low mid-burst: no beat, grant held, count unchanged (no timeout).
//  - win falls mid-burst: no beat that cycle; gnt=0 next cycle, IDLE, rr_ptr NOT advanced (owner resumes first).
//  - last with req low is ignored. Simultaneous requests: only the rr winner is granted, others wait.
//  - At most one wr_en per cycle; gnt never has more than one bit set.
//  - rr_ptr width $clog2(N_REQ); wraps N_REQ-1 -> 0. beat_cnt width $clog2(MAX_BURST+1).
// CONFIGURATION
//  - VRAM_ARB_CLEAR_EN defined: clear ports exist; clear_req latches pending flag + color.
//    Pending clear takes priority over requesters at next IDLE (current burst finishes normally).
//    CLEAR state: one write per win cycle, addr 0..DEPTH-1, gnt=0 throughout; pauses while win=0.
//    clear_done pulses the cycle after the DEPTH-1 write appears on wr_en; then IDLE, rr_ptr unchanged.
//    clear_req during CLEAR or while already pending: ignored.
//  - Not defined: clear ports, CLEAR state and pending logic absent; behaviour otherwise identical.
// STRUCTURE
//  - Package vram_arb_pkg: state enum {IDLE, BURST, CLEAR}, default ADDR_W/DATA_W, FB_DEPTH constant.
//  - Sub-module vram_rr_pick: combinational round-robin picker (req, ptr -> onehot, idx, any).
// TESTING
//  1 Reset mid-burst: rst=1 while gnt=4'b0010 -> gnt=0, wr_en=0, busy=0 immediately (async).
//  2 req=4'b1111 all last=1, vblank=1 -> grants 0,1,2,3,0 in order, one wr_en per burst, dead cycle between.
//  3 req0 8-beat burst, addr 100..107, data 8'hE0, last on 8th -> wr_addr 100..107 one cycle after each beat.
//  4 MAX_BURST=4, req1 held with last=0 -> release after 4 beats, req2 granted next; req1 regains after rotation.
//  5 vblank drops after 3 beats of req3 -> 0 writes while vblank=0; on vblank=1 req3 regranted before req0.
//  6 (CLEAR_EN, DEPTH=16) clear_req, color 8'h03 during req0 burst -> burst completes, then addr 0..15 = 8'h03,
//    clear_done 1 cycle after addr 15; second clear_req mid-fill has no effect.

Source files
------------

// File: rtl/vram_arb_pkg.sv
// Shared types and defaults for the framebuffer write arbiter.
package vram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        CLEAR = 2'd2
    } state_t;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 8;
    localparam int FB_DEPTH   = 19200;

endpackage

// File: rtl/vram_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, cyclic.
module vram_rr_pick #(
    parameter int N_REQ = 4,
    parameter int PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] onehot,
    output logic [PTR_W-1:0] idx,
    output logic             any
);

    int j;

    // scan from ptr upward, wrapping; the first hit wins
    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        j      = 0;
        for (int k = 0; k < N_REQ; k++) begin
            j = (int'(ptr) + k) % N_REQ;
            if (!any && req[j]) begin
                any       = 1'b1;
                idx       = PTR_W'(j);
                onehot[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vram_write_arbiter.sv
// Round-robin, burst-locked arbiter for the single vga_ram write port.
// All write-port outputs and the grant are registered. Beats are optionally
// gated to vblank. Define VRAM_ARB_CLEAR_EN to add a full-screen fill engine
// that takes priority over requesters at the next idle point.
module vram_write_arbiter
    import vram_arb_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int DEPTH       = FB_DEPTH,
    parameter int MAX_BURST   = 64,
    parameter int GATE_VBLANK = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    vblank,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ-1:0]        last,
    input  logic [N_REQ*ADDR_W-1:0] addr,
    input  logic [N_REQ*DATA_W-1:0] data,
    output logic [N_REQ-1:0]        gnt,
    output logic                    wr_en,
    output logic [ADDR_W-1:0]       wr_addr,
    output logic [DATA_W-1:0]       wr_data,
    output logic                    busy
`ifdef VRAM_ARB_CLEAR_EN
    ,
    input  logic                    clear_req,
    input  logic [DATA_W-1:0]       clear_color,
    output logic                    clear_done
`endif
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    state_t             state;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   owner;
    logic [CNT_W-1:0]   beat_cnt;

    logic               win;
    logic [N_REQ-1:0]   pick_onehot;
    logic [PTR_W-1:0]   pick_idx;
    logic               pick_any;
    logic               beat;
    logic [CNT_W-1:0]   cnt_next;
    logic               hit_max;
    logic [PTR_W-1:0]   ptr_next;
    logic [ADDR_W-1:0]  own_addr;
    logic [DATA_W-1:0]  own_data;

`ifdef VRAM_ARB_CLEAR_EN
    logic               clr_pend;
    logic [DATA_W-1:0]  clr_color;
    logic [ADDR_W-1:0]  clr_addr;
    logic               clr_fin;
`endif

    vram_rr_pick #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_pick (
        .req    (req),
        .ptr    (rr_ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    assign win      = vblank | (GATE_VBLANK == 0);
    assign own_addr = addr[int'(owner)*ADDR_W +: ADDR_W];
    assign own_data = data[int'(owner)*DATA_W +: DATA_W];
    assign beat     = (state == BURST) & req[owner] & win;
    assign cnt_next = beat_cnt + 1'b1;
    assign hit_max  = (cnt_next == CNT_W'(MAX_BURST));
    assign ptr_next = (owner == PTR_W'(N_REQ - 1)) ? '0 : owner + 1'b1;
    assign busy     = (state != IDLE);

    // arbitration FSM with registered grant and write-port outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            rr_ptr   <= '0;
            owner    <= '0;
            beat_cnt <= '0;
`ifdef VRAM_ARB_CLEAR_EN
            clr_pend   <= 1'b0;
            clr_color  <= '0;
            clr_addr   <= '0;
            clr_fin    <= 1'b0;
            clear_done <= 1'b0;
`endif
        end else begin
            wr_en <= 1'b0;
`ifdef VRAM_ARB_CLEAR_EN
            clr_fin    <= 1'b0;
            clear_done <= clr_fin;
            // a request while one is pending or a fill is running is dropped
            if (clear_req && !clr_pend && state != CLEAR) begin
                clr_pend  <= 1'b1;
                clr_color <= clear_color;
            end
`endif
            case (state)
                IDLE: begin
`ifdef VRAM_ARB_CLEAR_EN
                    if (clr_pend) begin
                        state    <= CLEAR;
                        clr_pend <= 1'b0;
                        clr_addr <= '0;
                    end else
`endif
                    if (win && pick_any) begin
                        state    <= BURST;
                        gnt      <= pick_onehot;
                        owner    <= pick_idx;
                        beat_cnt <= '0;
                    end
                end
                BURST: begin
                    if (beat) begin
                        wr_en    <= 1'b1;
                        wr_addr  <= own_addr;
                        wr_data  <= own_data;
                        beat_cnt <= cnt_next;
                        if (last[owner] || hit_max) begin
                            gnt    <= '0;
                            state  <= IDLE;
                            rr_ptr <= ptr_next;
                        end
                    end else if (!win) begin
                        // window closed: drop grant but keep pointer so owner resumes first
                        gnt   <= '0;
                        state <= IDLE;
                    end
                end
`ifdef VRAM_ARB_CLEAR_EN
                CLEAR: begin
                    if (win) begin
                        wr_en   <= 1'b1;
                        wr_addr <= clr_addr;
                        wr_data <= clr_color;
                        if (clr_addr == ADDR_W'(DEPTH - 1)) begin
                            state   <= IDLE;
                            clr_fin <= 1'b1;
                        end else begin
                            clr_addr <= clr_addr + 1'b1;
                        end
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule
